alu_variable_width: RTL and testbench
=====================================

ALU_VARIABLE_WIDTH -- requirements
Module: alu_variable_width

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result word width in bits (legal range 2..64).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all registered state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have input a, WIDTH bits, signed two's-complement operand A.
REQ-005 The block SHALL have input b, WIDTH bits, signed two's-complement operand B.
REQ-006 The block SHALL have input control, 2 bits, the operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 The block SHALL have output c, WIDTH bits, the signed combinational result of the selected operation.
REQ-008 The block SHALL have output c_q, WIDTH bits, c registered on the rising edge of clk.
REQ-009 The block SHALL have output ovf_q, 1 bit, the registered signed-overflow flag for the registered result.
REQ-010 The block SHALL have output dz_q, 1 bit, the registered divide-by-zero flag for the registered result.

Function
REQ-011 c SHALL be purely combinational from a, b and control: zero latency, no dependence on clk or rst, and valid within the same cycle the inputs change.
REQ-012 Add SHALL compute a+b, truncated to the low WIDTH bits with two's-complement wrap.
REQ-013 Subtract SHALL compute a-b, truncated to the low WIDTH bits with two's-complement wrap.
REQ-014 Multiply SHALL compute the full 2*WIDTH signed product; c SHALL take its low WIDTH bits.
REQ-015 Divide SHALL compute the signed quotient a/b, truncated toward zero; the remainder is discarded.
REQ-016 For divide with b=0, c SHALL be 0 and the divide-by-zero condition SHALL be true.
REQ-017 For divide with a = most-negative value and b = -1, c SHALL be the most-negative value and overflow SHALL be true.
REQ-018 The overflow condition SHALL be defined per operation:
- add/sub: the true signed result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- multiply: the 2*WIDTH-bit product does not equal the sign-extension of its low WIDTH bits.
- divide: only the case in REQ-017.
REQ-019 The divide-by-zero condition SHALL be true only for control=11 with b=0, and overflow SHALL be false in that case.
REQ-020 On each rising clk edge with rst=0, c_q, ovf_q and dz_q SHALL load the current c, overflow and divide-by-zero values (one-cycle latency).
REQ-021 No X or Z SHALL appear on any output for known inputs, including the divide-by-zero case.

Reset
REQ-022 On a rising clk edge with rst=1, c_q, ovf_q and dz_q SHALL become 0, overriding any load.
REQ-023 While rst=1, c SHALL continue to track the inputs combinationally.
REQ-024 After rst deasserts, the first rising edge SHALL load normally.

Verification (WIDTH=8; c checked mid-cycle after input change; registered outputs checked after the next clock edge)
REQ-025 Add: control=00, a=5, b=3 -> c=8, ovf 0. Also a=100, b=100 -> c=-56, ovf_q=1 after the edge.
REQ-026 Subtract: control=01, a=3, b=5 -> c=-2, ovf 0. Also a=-128, b=1 -> c=127, ovf 1.
REQ-027 Multiply: control=10, a=-4, b=6 -> c=-24, ovf 0. Also a=16, b=16 -> c=0, ovf 1.
REQ-028 Divide: control=11:
- a=-7, b=2 -> c=-3.
- a=7, b=0 -> c=0, dz_q=1, ovf_q=0.
- a=-128, b=-1 -> c=-128, ovf_q=1.
REQ-029 Reset: hold rst=1 for one edge after a nonzero result -> c_q=0, ovf_q=0, dz_q=0 while c still shows the live result.
REQ-030 Random sweep: at least 1000 random (a, b, control) vectors, with c and the registered outputs compared against a reference model per REQ-012..REQ-019.

Source files
------------

// File: rtl/alu_variable_width.sv
// Signed add/sub/mul/div ALU of parameterised width.
// Combinational result c, plus registered result and overflow/div-by-zero flags.
module alu_variable_width #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             ovf_q,
    output logic             dz_q
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [WIDTH:0]     sum;
    logic signed [WIDTH:0]     diff;
    logic signed [2*WIDTH-1:0] prod;
    logic                      div_zero;
    logic                      div_ovf;
    logic        [WIDTH-1:0]   dvs;
    logic        [WIDTH-1:0]   quot;
    logic                      ovf_d;
    logic                      dz_d;

    assign sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign prod = $signed(a) * $signed(b);

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MIN_VAL) && (b == NEG_ONE);

    // Steer the divider to a/1 for the special cases so it never sees /0 or MIN/-1.
    assign dvs  = (div_zero || div_ovf) ? ONE : b;
    assign quot = $signed(a) / $signed(dvs);

    always_comb begin
        c     = '0;
        ovf_d = 1'b0;
        dz_d  = 1'b0;
        case (control)
            2'b00: begin
                c     = sum[WIDTH-1:0];
                ovf_d = sum[WIDTH] ^ sum[WIDTH-1];
            end
            2'b01: begin
                c     = diff[WIDTH-1:0];
                ovf_d = diff[WIDTH] ^ diff[WIDTH-1];
            end
            2'b10: begin
                c     = prod[WIDTH-1:0];
                ovf_d = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
            end
            2'b11: begin
                if (div_zero) begin
                    dz_d = 1'b1;
                end else begin
                    c     = quot;
                    ovf_d = div_ovf;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            c_q   <= c;
            ovf_q <= ovf_d;
            dz_q  <= dz_d;
        end
    end

endmodule

// File: tb/tb_alu_variable_width.sv
// Bench for alu_variable_width (WIDTH=8): directed literal vectors,
// reset override, and a random sweep against an integer-arithmetic model.
module tb_alu_variable_width;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   control;
    logic [W-1:0] c;
    logic [W-1:0] c_q;
    logic         ovf_q;
    logic         dz_q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_variable_width #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .control (control),
        .c       (c),
        .c_q     (c_q),
        .ovf_q   (ovf_q),
        .dz_q    (dz_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // True signed result in wide integers, then range-check and truncate.
    function automatic void ref_model(input logic [W-1:0] ia,
                                      input logic [W-1:0] ib,
                                      input logic [1:0] ctl,
                                      output logic [W-1:0] oc,
                                      output logic oovf,
                                      output logic odz);
        longint sa, sb, r;
        longint lo, hi;
        sa   = longint'($signed(ia));
        sb   = longint'($signed(ib));
        lo   = -(64'sd1 <<< (W-1));
        hi   = (64'sd1 <<< (W-1)) - 1;
        odz  = 1'b0;
        case (ctl)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = sa * sb;
            default: begin
                if (sb == 0) begin
                    r   = 0;
                    odz = 1'b1;
                end else begin
                    r = sa / sb;
                end
            end
        endcase
        oovf = (r < lo) || (r > hi);
        oc   = r[W-1:0];
    endfunction

    logic [W-1:0] exp_cq;
    logic         exp_ovf;
    logic         exp_dz;
    logic         exp_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_cq  = '0;
            exp_ovf = 1'b0;
            exp_dz  = 1'b0;
        end else begin
            ref_model(a, b, control, exp_cq, exp_ovf, exp_dz);
        end
        exp_valid = 1'b1;
    end

    always @(negedge clk) begin
        logic [W-1:0] mc;
        logic         mo;
        logic         md;
        if (exp_valid) begin
            ref_model(a, b, control, mc, mo, md);
            chk("c_model", c, mc);
            chk("c_q_model", c_q, exp_cq);
            chk("ovf_q_model", ovf_q, exp_ovf);
            chk("dz_q_model", dz_q, exp_dz);
        end
    end

    localparam int NV = 12;
    logic [1:0]   v_ctl [NV] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1};
    logic [W-1:0] v_a   [NV] = '{8'd5, 8'd100, 8'd3, 8'h80, 8'hFC, 8'd16,
                                 8'hF9, 8'd7, 8'h80, 8'd7, 8'h80, 8'd127};
    logic [W-1:0] v_b   [NV] = '{8'd3, 8'd100, 8'd5, 8'd1, 8'd6, 8'd16,
                                 8'd2, 8'd0, 8'hFF, 8'hFE, 8'hFF, 8'hFF};
    logic [W-1:0] v_c   [NV] = '{8'd8, 8'hC8, 8'hFE, 8'h7F, 8'hE8, 8'h00,
                                 8'hFD, 8'h00, 8'h80, 8'hFD, 8'h80, 8'h80};
    logic         v_o   [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         v_d   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'hFF;
            2: return 8'h00;
            3: return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] mc;
        logic         mo;
        logic         md;
        rst     = 1'b1;
        a       = '0;
        b       = '0;
        control = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_c_q", c_q, 8'd0);
        chk("reset_ovf_q", ovf_q, 1'b0);
        chk("reset_dz_q", dz_q, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            control = v_ctl[i];
            a       = v_a[i];
            b       = v_b[i];
            ref_model(v_a[i], v_b[i], v_ctl[i], mc, mo, md);
            chk($sformatf("lit_model_c[%0d]", i), mc, v_c[i]);
            chk($sformatf("lit_model_ovf[%0d]", i), mo, v_o[i]);
            chk($sformatf("lit_model_dz[%0d]", i), md, v_d[i]);
            @(negedge clk);
            chk($sformatf("lit_c[%0d]", i), c, v_c[i]);
            @(posedge clk);
            #1;
            chk($sformatf("lit_c_q[%0d]", i), c_q, v_c[i]);
            chk($sformatf("lit_ovf_q[%0d]", i), ovf_q, v_o[i]);
            chk($sformatf("lit_dz_q[%0d]", i), dz_q, v_d[i]);
        end

        // Reset overrides a live overflowing result; c keeps tracking.
        control = 2'd0;
        a       = 8'd100;
        b       = 8'd100;
        @(posedge clk);
        #1;
        chk("pre_rst_c_q", c_q, 8'hC8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_c_q", c_q, 8'd0);
        chk("rst_ovf_q", ovf_q, 1'b0);
        chk("rst_dz_q", dz_q, 1'b0);
        chk("rst_live_c", c, 8'hC8);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_c_q", c_q, 8'hC8);
        chk("post_rst_ovf_q", ovf_q, 1'b1);

        for (int i = 0; i < 1200; i++) begin
            a       = pick_val();
            b       = pick_val();
            control = 2'($urandom_range(0, 3));
            rst     = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
